pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline.
//  - Detects load-use hazards: inserts a 1-cycle bubble into ID/EX.
//  - Flushes IF/ID and ID/EX on a taken branch.
//  - Runs the data-memory handshake for the MEM stage: freezes every pipeline register
//    (EX/MEM included) while memory is not ready, with a wait-time watchdog.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/mem_wait_timer.sv | 47 ++++
 rtl/pipeline_stall_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared definitions for the pipeline stall/flush sequencer:
//   - state_t         : memory-handshake FSM encoding (RUN / WAIT / ERROR)
//   - REG_ZERO        : register number of the hard-wired zero register
//   - DEF_MEM_TIMEOUT : default number of wait cycles before the watchdog fires
//   - DEF_CNT_W       : default width of the wait counter
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         DEF_MEM_TIMEOUT = 16;
    localparam int         DEF_CNT_W       = 5;

endpackage

// File: rtl/mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
//   Counts cycles spent waiting on data memory and flags the watchdog limit.
//   The counter saturates at all-ones so it can never wrap back below the
//   limit while the FSM sits in ERROR.
// Ports
//   clk        in  pipeline clock, rising edge
//   reset      in  asynchronous active-low reset
//   i_clear    in  restart the count (entering the wait state)
//   i_count    in  one more cycle spent waiting
//   o_timeout  out count has reached MEM_TIMEOUT-1
// ----------------------------------------------------------------------------
module mem_wait_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    // Saturating wait counter; clear wins over count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clear) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_count && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_timeout = (r_cnt == LIMIT);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Stall/flush sequencer for a 5-stage MIPS pipeline: load-use bubble,
//   taken-branch flush, and the data-memory handshake with a watchdog.
//   Optional feature macro: PIPE_STALL_PERF_EN enables the two 32-bit
//   performance counters; without it both counter ports are tied to zero.
// Ports
//   clk, reset (async active-low)
//   id_rs, id_rt, ex_MemRead, ex_Write_Register  hazard detection inputs
//   ex_branch_taken                              branch resolved taken in EX
//   mem_MemRead, mem_MemWrite, mem_ack           MEM-stage handshake inputs
//   mem_req                                      data memory request
//   pc_write, if_id_write, id_ex_write, ex_mem_write  register enables
//   if_id_flush, id_ex_flush, mem_wb_bubble      NOP insertion controls
//   mem_error                                    sticky watchdog flag
//   stall_cycles, flush_count                    performance counters
// ----------------------------------------------------------------------------
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_Write_Register,
    input  logic        ex_branch_taken,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_flush,
    output logic        ex_mem_write,
    output logic        mem_wb_bubble,
    output logic        mem_error,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    state_t r_state;
    state_t w_state_next;
    logic   w_mem_access;
    logic   w_freeze;
    logic   w_load_use;
    logic   w_timeout;
    logic   w_enter_wait;

    assign w_mem_access = mem_MemRead | mem_MemWrite;
    assign w_freeze     = (w_mem_access & ~mem_ack) | (r_state == ERROR);
    assign w_load_use   = ex_MemRead & (ex_Write_Register != REG_ZERO) &
                          ((ex_Write_Register == id_rs) | (ex_Write_Register == id_rt));
    assign w_enter_wait = (r_state == RUN) & (w_state_next == WAIT);

    assign mem_req   = w_mem_access & (r_state != ERROR);
    // ERROR is terminal, so being in it is the sticky flag itself.
    assign mem_error = (r_state == ERROR);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_enter_wait),
        .i_count   (r_state == WAIT),
        .o_timeout (w_timeout)
    );

    // Handshake FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake FSM next-state logic; an illegal encoding falls into ERROR.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_mem_access && !mem_ack) begin
                    w_state_next = WAIT;
                end else begin
                    w_state_next = RUN;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    w_state_next = RUN;
                end else if (w_timeout) begin
                    w_state_next = ERROR;
                end else begin
                    w_state_next = WAIT;
                end
            end
            ERROR:   w_state_next = ERROR;
            default: w_state_next = ERROR;
        endcase
    end

    // Enables and flushes: freeze beats branch, branch beats load-use.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (w_freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            pc_write = 1'b1;
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (!pc_write) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (if_id_flush || id_ex_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//   Directed bench for pipeline_stall_ctrl: a table of single-cycle vectors
//   in the RUN state, then hand-written multi-cycle sequences for memory wait,
//   branch during wait, watchdog timeout and asynchronous reset.
//   Output vector bit order:
//   {mem_req, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
//    ex_mem_write, mem_wb_bubble}
// ----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam int TIMEOUT = 16;

    localparam logic [7:0] V_IDLE   = 8'b0110_1010;
    localparam logic [7:0] V_LU     = 8'b0000_1110;
    localparam logic [7:0] V_BR     = 8'b0111_1110;
    localparam logic [7:0] V_FRZ    = 8'b1000_0001;
    localparam logic [7:0] V_ERR    = 8'b0000_0001;
    localparam logic [7:0] V_REQ    = 8'b1110_1010;
    localparam logic [7:0] V_REQ_LU = 8'b1000_1110;
    localparam logic [7:0] V_REQ_BR = 8'b1111_1110;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_Write_Register;
    logic        ex_MemRead, ex_branch_taken, mem_MemRead, mem_MemWrite, mem_ack;
    logic        mem_req, pc_write, if_id_write, if_id_flush, id_ex_write;
    logic        id_ex_flush, ex_mem_write, mem_wb_bubble, mem_error;
    logic [31:0] stall_cycles, flush_count;

    int checks   = 0;
    int failures = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ex_wr;
        logic       ex_mrd;
        logic       br;
        logic       mrd;
        logic       mwr;
        logic       ack;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .ex_MemRead        (ex_MemRead),
        .ex_Write_Register (ex_Write_Register),
        .ex_branch_taken   (ex_branch_taken),
        .mem_MemRead       (mem_MemRead),
        .mem_MemWrite      (mem_MemWrite),
        .mem_ack           (mem_ack),
        .mem_req           (mem_req),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write),
        .if_id_flush       (if_id_flush),
        .id_ex_write       (id_ex_write),
        .id_ex_flush       (id_ex_flush),
        .ex_mem_write      (ex_mem_write),
        .mem_wb_bubble     (mem_wb_bubble),
        .mem_error         (mem_error),
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count)
    );

    wire [7:0] w_obs = {mem_req, pc_write, if_id_write, if_id_flush,
                        id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_wr,
                         input logic ex_mrd, input logic br, input logic mrd,
                         input logic mwr, input logic ack);
        id_rs             = rs;
        id_rt             = rt;
        ex_Write_Register = ex_wr;
        ex_MemRead        = ex_mrd;
        ex_branch_taken   = br;
        mem_MemRead       = mrd;
        mem_MemWrite      = mwr;
        mem_ack           = ack;
    endtask

    // One pipeline cycle: drive at negedge, check before the next posedge,
    // and advance the bench's own counter model from the expected vector.
    task automatic step(input string name, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] ex_wr, input logic ex_mrd, input logic br,
                        input logic mrd, input logic mwr, input logic ack,
                        input logic [7:0] exp, input logic exp_err);
        @(negedge clk);
        drive(rs, rt, ex_wr, ex_mrd, br, mrd, mwr, ack);
        #1;
        chk(name, {24'd0, w_obs}, {24'd0, exp});
        chk({name, "_err"}, {31'd0, mem_error}, {31'd0, exp_err});
        if (!exp[6]) m_stall++;
        if (exp[4] || exp[2]) m_flush++;
    endtask

    task automatic check_counters(input string name);
        logic [31:0] e_stall;
        logic [31:0] e_flush;
`ifdef PIPE_STALL_PERF_EN
        e_stall = 32'(m_stall);
        e_flush = 32'(m_flush);
`else
        e_stall = 32'd0;
        e_flush = 32'd0;
`endif
        chk({name, "_stall"}, stall_cycles, e_stall);
        chk({name, "_flush"}, flush_count, e_flush);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0]  = '{"idle",        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE};
        vecs[1]  = '{"lu_rs",       5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU};
        vecs[2]  = '{"lu_rt",       5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU};
        vecs[3]  = '{"lu_r0",       5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE};
        vecs[4]  = '{"no_load",     5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE};
        vecs[5]  = '{"no_match",    5'd4, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE};
        vecs[6]  = '{"branch",      5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BR};
        vecs[7]  = '{"branch_lu",   5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V_BR};
        vecs[8]  = '{"store_0wait", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_REQ};
        vecs[9]  = '{"load_0w_lu",  5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, V_REQ_LU};
        vecs[10] = '{"ack_only",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, V_IDLE};

        // Reset state
        reset = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_outputs", {24'd0, w_obs}, {24'd0, V_IDLE});
        chk("rst_err", {31'd0, mem_error}, 32'd0);
        check_counters("rst");
        @(negedge clk);
        reset = 1'b1;

        // Single-cycle vectors in RUN
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].name, vecs[i].rs, vecs[i].rt, vecs[i].ex_wr, vecs[i].ex_mrd,
                 vecs[i].br, vecs[i].mrd, vecs[i].mwr, vecs[i].ack, vecs[i].exp, 1'b0);
        end
        @(posedge clk);
        #1;
        check_counters("table");

        // Load waits three cycles, released on the ack cycle
        for (int c = 0; c < 3; c++) begin
            step("wait3_frozen", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_FRZ, 1'b0);
        end
        step("wait3_release", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, V_REQ, 1'b0);
        step("after_wait3", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE, 1'b0);

        // Branch + load-use held during WAIT: acted on only at release
        for (int c = 0; c < 2; c++) begin
            step("br_in_wait", 5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, V_FRZ, 1'b0);
        end
        step("br_release", 5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, V_REQ_BR, 1'b0);
        step("after_br", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE, 1'b0);
        @(posedge clk);
        #1;
        check_counters("seq");

        // Watchdog: ack never arrives
        for (int c = 0; c <= TIMEOUT; c++) begin
            step("timeout_wait", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_FRZ, 1'b0);
        end
        step("timeout_err", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_ERR, 1'b1);
        step("err_late_ack", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, V_ERR, 1'b1);
        step("err_idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_ERR, 1'b1);

        // Asynchronous reset out of ERROR, mid-cycle
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        m_stall = 0;
        m_flush = 0;
        #1;
        chk("arst_err_outputs", {24'd0, w_obs}, {24'd0, V_IDLE});
        chk("arst_err_flag", {31'd0, mem_error}, 32'd0);
        check_counters("arst_err");
        @(negedge clk);
        reset = 1'b1;
        step("post_err_rst", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE, 1'b0);

        // Asynchronous reset in the middle of WAIT
        step("w_enter", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ, 1'b0);
        step("w_hold", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_stall = 0;
        m_flush = 0;
        #1;
        chk("arst_wait_outputs", {24'd0, w_obs}, {24'd0, V_IDLE});
        chk("arst_wait_flag", {31'd0, mem_error}, 32'd0);
        check_counters("arst_wait");
        @(negedge clk);
        reset = 1'b1;
        step("post_wait_rst", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE, 1'b0);
        step("post_rst_lu", 5'd4, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU, 1'b0);
        step("post_rst_0w", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_REQ, 1'b0);
        @(posedge clk);
        #1;
        check_counters("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
